pin_entry_controller: RTL and testbench
=======================================

# pin_entry_controller

Sequencer for the combination-lock PIN path. It turns button presses into digit-select, shift and clear strobes for the PIN shift register. After DIGITS entries it issues a single check strobe to the lock state machine and waits for the verdict. It counts consecutive failures and enforces a timed lockout. It sits between the board buttons and the existing pin register / lock FSM, replacing the free-running up/down counter and count-to-4 trigger.

## Interface
- DIGITS, 4: PIN length in hex digits (2..8)
- MAX_FAILS, 3: consecutive mismatches that trigger lockout (1..15)
- LOCKOUT_CYCLES, 100000000: lockout duration in clk cycles (≥2)
- TIMEOUT_CYCLES, 500000000: inactivity timeout in clk cycles (only with ENTRY_TIMEOUT_EN)

Ports:
- clk  in  1  system clock (100 MHz board clock)
- rst  in  1  synchronous, active-low reset
- btn_up, btn_down, btn_enter, btn_clear  in  1 each  debounced button levels, asynchronous to clk
- result_valid  in  1  one-cycle verdict strobe from lock FSM
- result_match  in  1  verdict; valid only with result_valid
- digit  out  4  currently selected hex digit
- shift_en  out  1  one-cycle pulse: shift `digit` into PIN register
- pin_clr  out  1  one-cycle pulse: clear PIN register
- check  out  1  one-cycle pulse: PIN complete, evaluate
- digit_count  out  $clog2(DIGITS+1)  digits entered so far
- fail_count  out  4  consecutive mismatches
- busy  out  1  high in CHECK, WAIT, LOCKOUT
- lockout  out  1  high in LOCKOUT

## Operation
- Each button passes through a 2-flop synchronizer and a rising-edge detector. Only edges act. Held levels do nothing more.
- States: ENTRY, CHECK, WAIT, LOCKOUT. Reset state is ENTRY.
- Reset values: digit=0, digit_count=0, fail_count=0, and all strobes, busy and lockout are 0.
- ENTRY, priority clear > enter > up/down:
  - clear: pin_clr pulse, digit_count=0, digit=0.
  - enter: shift_en pulse carrying the pre-update digit. Then digit_count+1 and digit=0. If the new count equals DIGITS, the next state is CHECK.
  - up: digit+1, wrapping F→0.
  - down: digit−1, wrapping 0→F.
  - up and down on the same cycle: digit unchanged.
  - enter and up/down on the same cycle: the up/down is discarded.
- CHECK: check pulse for exactly one cycle, then WAIT.
- WAIT: hold until result_valid.
  - match: fail_count=0, pin_clr, digit_count=0, go to ENTRY.
  - mismatch: fail_count+1 and pin_clr. If the new fail_count equals MAX_FAILS, load the lockout timer and go to LOCKOUT. Otherwise go to ENTRY with digit_count=0.
- LOCKOUT: timer counts down LOCKOUT_CYCLES. On expiry: fail_count=0, go to ENTRY.
- Button edges outside ENTRY are dropped, not queued.
- result_valid outside WAIT is ignored.
- Reset asserted mid-operation returns to reset values on the next edge. No strobe fires in that cycle.

## Timing
- Button rising at the input: the action is visible 3 clk edges later (2 sync + 1 edge detect/register).
- The enter completing the PIN drives shift_en in cycle N, check in N+1, and busy from N+1.
- result_valid in cycle M: pin_clr and the state change occur in M+1.
- LOCKOUT lasts exactly LOCKOUT_CYCLES cycles. lockout falls on the cycle ENTRY is re-entered.
- All outputs are registered.

## Configuration
- ENTRY_TIMEOUT_EN defined:
  - In ENTRY with digit_count>0, a timer restarts on every accepted button edge.
  - After TIMEOUT_CYCLES cycles with no edge: pin_clr pulse, digit_count=0, digit=0.
  - fail_count is unchanged.
- ENTRY_TIMEOUT_EN undefined: no timer logic. A partial entry is held indefinitely.

## Structure
- Shared package pin_entry_pkg holds:
  - the state enum (ENTRY, CHECK, WAIT, LOCKOUT)
  - digit width constant 4
  - fail_count width constant 4
- One sub-module, btn_edge: 2-flop synchronizer plus rising-edge pulse, clk and rst only. Instantiated four times.
- The timers are inline down-counters.

## Test plan
Bench parameters: DIGITS=4, MAX_FAILS=3, LOCKOUT_CYCLES=8, TIMEOUT_CYCLES=16.

- up×3, enter, down×1 (0→F), enter, enter, enter → shift_en digits 3,F,0,0; one check pulse the cycle after the 4th shift_en; busy=1.
- Full PIN, then result_valid=1 with match=1 → pin_clr next cycle, digit_count=0, fail_count=0, state ENTRY.
- Three full PINs, each answered with match=0 → fail_count 1,2,3; lockout high for exactly 8 cycles; enter pressed during lockout gives no shift_en; after expiry fail_count=0.
- Enter and clear edges on the same cycle after 2 digits → pin_clr only, no shift_en, digit_count=0. Up and down on the same cycle → digit unchanged.
- ENTRY_TIMEOUT_EN build: 1 digit entered, then 16 idle cycles → pin_clr, digit_count=0. Non-EN build, same stimulus → digit_count stays 1.
- rst low during WAIT → next cycle all outputs at reset values; a later result_valid is ignored.

Source files
------------

// File: rtl/pin_entry_pkg.sv
// rtl/pin_entry_pkg.sv - shared state type, field widths and digit stepping for the PIN entry path
package pin_entry_pkg;

  localparam int DIGIT_W = 4;
  localparam int FAIL_W  = 4;

  typedef enum logic [1:0] {
    ENTRY   = 2'd0,
    CHECK   = 2'd1,
    WAIT    = 2'd2,
    LOCKOUT = 2'd3
  } pin_state_t;

  typedef logic [DIGIT_W-1:0] digit_t;

  // Up and down together cancel; both directions wrap through the full hex range.
  function automatic digit_t stepDigit(input digit_t d, input logic up, input logic down);
    digit_t r;
    case ({up, down})
      2'b10:   r = d + DIGIT_W'(1);
      2'b01:   r = d - DIGIT_W'(1);
      default: r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// rtl/btn_edge.sv - two-flop synchronizer plus single-cycle rising-edge pulse for one button
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic [2:0] syncPipe;

  always_ff @(posedge clk) begin
    if (!rst) begin
      syncPipe <= '0;
    end else begin
      syncPipe <= {syncPipe[1:0], btn};
    end
  end

  assign rise = syncPipe[1] & ~syncPipe[2];

endmodule

// File: rtl/pin_entry_controller.sv
// rtl/pin_entry_controller.sv - button-to-strobe sequencer for the PIN path with failure lockout
// Optional idle clear of a partial entry when ENTRY_TIMEOUT_EN is defined.
module pin_entry_controller
  import pin_entry_pkg::*;
#(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 100000000,
  parameter int unsigned TIMEOUT_CYCLES = 500000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_up,
  input  logic                        btn_down,
  input  logic                        btn_enter,
  input  logic                        btn_clear,
  input  logic                        result_valid,
  input  logic                        result_match,
  output logic [DIGIT_W-1:0]          digit,
  output logic                        shift_en,
  output logic                        pin_clr,
  output logic                        check,
  output logic [$clog2(DIGITS+1)-1:0] digit_count,
  output logic [FAIL_W-1:0]           fail_count,
  output logic                        busy,
  output logic                        lockout
);

  localparam int COUNT_W = $clog2(DIGITS + 1);
  localparam int LOCK_W  = $clog2(LOCKOUT_CYCLES);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(DIGITS);
  localparam logic [FAIL_W-1:0]  FAIL_LIMIT = FAIL_W'(MAX_FAILS);
  localparam logic [LOCK_W-1:0]  LOCK_LOAD  = LOCK_W'(LOCKOUT_CYCLES - 1);

  pin_state_t         state;
  logic [LOCK_W-1:0]  lockTimer;
  logic               upEdge, downEdge, enterEdge, clrEdge;
  logic               idleExpired;
  logic [COUNT_W-1:0] countNext;
  logic [FAIL_W-1:0]  failNext;
  digit_t             digitBase;

  btn_edge upSync    (.clk(clk), .rst(rst), .btn(btn_up),    .rise(upEdge));
  btn_edge downSync  (.clk(clk), .rst(rst), .btn(btn_down),  .rise(downEdge));
  btn_edge enterSync (.clk(clk), .rst(rst), .btn(btn_enter), .rise(enterEdge));
  btn_edge clearSync (.clk(clk), .rst(rst), .btn(btn_clear), .rise(clrEdge));

  assign countNext = digit_count + COUNT_W'(1);
  assign failNext  = fail_count + FAIL_W'(1);
  // The PIN register samples digit during shift_en, so the zeroing lands one cycle later.
  assign digitBase = shift_en ? '0 : digit;

`ifdef ENTRY_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idleTimer;
  logic              anyEdge;

  assign anyEdge = upEdge | downEdge | enterEdge | clrEdge;

  always_ff @(posedge clk) begin
    if (!rst) begin
      idleTimer <= '0;
    end else if (state == ENTRY && anyEdge) begin
      idleTimer <= IDLE_LOAD;
    end else if (state == ENTRY && digit_count != '0 && idleTimer != '0) begin
      idleTimer <= idleTimer - IDLE_W'(1);
    end
  end

  assign idleExpired = (state == ENTRY) && (digit_count != '0) && !anyEdge && (idleTimer == '0);
`else
  assign idleExpired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ENTRY;
      digit       <= '0;
      digit_count <= '0;
      fail_count  <= '0;
      shift_en    <= 1'b0;
      pin_clr     <= 1'b0;
      check       <= 1'b0;
      busy        <= 1'b0;
      lockout     <= 1'b0;
      lockTimer   <= '0;
    end else begin
      shift_en <= 1'b0;
      pin_clr  <= 1'b0;
      check    <= 1'b0;
      if (shift_en) begin
        digit <= '0;
      end

      case (state)
        ENTRY: begin
          if (clrEdge || idleExpired) begin
            pin_clr     <= 1'b1;
            digit_count <= '0;
            digit       <= '0;
          end else if (enterEdge) begin
            shift_en    <= 1'b1;
            digit_count <= countNext;
            if (countNext == FULL_COUNT) begin
              state <= CHECK;
            end
          end else if (upEdge || downEdge) begin
            digit <= stepDigit(digitBase, upEdge, downEdge);
          end
        end

        CHECK: begin
          check <= 1'b1;
          busy  <= 1'b1;
          state <= WAIT;
        end

        WAIT: begin
          if (result_valid) begin
            pin_clr     <= 1'b1;
            digit_count <= '0;
            if (result_match) begin
              fail_count <= '0;
              busy       <= 1'b0;
              state      <= ENTRY;
            end else if (failNext == FAIL_LIMIT) begin
              fail_count <= failNext;
              lockTimer  <= LOCK_LOAD;
              lockout    <= 1'b1;
              state      <= LOCKOUT;
            end else begin
              fail_count <= failNext;
              busy       <= 1'b0;
              state      <= ENTRY;
            end
          end
        end

        LOCKOUT: begin
          if (lockTimer == '0) begin
            fail_count <= '0;
            lockout    <= 1'b0;
            busy       <= 1'b0;
            state      <= ENTRY;
          end else begin
            lockTimer <= lockTimer - LOCK_W'(1);
          end
        end

        default: state <= ENTRY;
      endcase
    end
  end

endmodule

// File: tb/tb_pin_entry_controller.sv
// tb/tb_pin_entry_controller.sv - directed plus randomized self-checking bench for pin_entry_controller
module tb_pin_entry_controller;

  localparam int DIGITS         = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 8;
  localparam int TIMEOUT_CYCLES = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_enter = 1'b0, btn_clear = 1'b0;
  logic       result_valid = 1'b0, result_match = 1'b0;
  logic [3:0] digit;
  logic       shift_en, pin_clr, check;
  logic [2:0] digit_count;
  logic [3:0] fail_count;
  logic       busy, lockout;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int shiftSeen = 0, clrSeen = 0, checkSeen = 0;
  int lastShiftCyc = -1, lastCheckCyc = -1;
  logic [3:0] shiftLog[$];

  // Reference model: PIN entry as plain arithmetic and counters.
  int mDigit = 0, mCount = 0, mFails = 0;
  int expShift = 0, expClr = 0, expCheck = 0;
  bit mBusy = 1'b0, mLock = 1'b0;
  int expDigits[$];

  pin_entry_controller #(
    .DIGITS(DIGITS), .MAX_FAILS(MAX_FAILS),
    .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .btn_up(btn_up), .btn_down(btn_down), .btn_enter(btn_enter), .btn_clear(btn_clear),
    .result_valid(result_valid), .result_match(result_match),
    .digit(digit), .shift_en(shift_en), .pin_clr(pin_clr), .check(check),
    .digit_count(digit_count), .fail_count(fail_count), .busy(busy), .lockout(lockout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    if (shift_en) begin shiftSeen++; shiftLog.push_back(digit); lastShiftCyc = cyc; end
    if (pin_clr) clrSeen++;
    if (check) begin checkSeen++; lastCheckCyc = cyc; end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic checkState(input string tag);
    chk({tag, ".digit"}, digit, mDigit);
    chk({tag, ".digit_count"}, digit_count, mCount);
    chk({tag, ".fail_count"}, fail_count, mFails);
    chk({tag, ".busy"}, busy, mBusy);
    chk({tag, ".lockout"}, lockout, mLock);
    chk({tag, ".shifts"}, shiftSeen, expShift);
    chk({tag, ".clears"}, clrSeen, expClr);
    chk({tag, ".checks"}, checkSeen, expCheck);
    if (shiftSeen == expShift && expShift > 0) chk({tag, ".shift_digit"}, shiftLog[$], expDigits[$]);
  endtask

  task automatic pressRaw(input logic u, input logic d, input logic e, input logic c);
    @(negedge clk);
    btn_up = u; btn_down = d; btn_enter = e; btn_clear = c;
    repeat (4) @(negedge clk);
    btn_up = 1'b0; btn_down = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic doPress(input logic u, input logic d, input logic e, input logic c);
    pressRaw(u, d, e, c);
    if (!mBusy) begin
      if (c) begin
        mDigit = 0; mCount = 0; expClr++;
      end else if (e) begin
        expDigits.push_back(mDigit); expShift++; mDigit = 0; mCount++;
        if (mCount == DIGITS) begin mBusy = 1'b1; expCheck++; end
      end else if (u && !d) begin
        mDigit = (mDigit + 1) % 16;
      end else if (d && !u) begin
        mDigit = (mDigit + 15) % 16;
      end
    end
    checkState("press");
  endtask

  task automatic enterPin();
    repeat (DIGITS) doPress(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic verdict(input logic m);
    @(negedge clk); result_valid = 1'b1; result_match = m;
    @(negedge clk); result_valid = 1'b0; result_match = 1'b0;
    if (m) mFails = 0; else mFails++;
    mCount = 0; mDigit = 0; expClr++;
    mLock = (mFails == MAX_FAILS);
    mBusy = mLock;
    chk("verdict.pin_clr_next", pin_clr, 1'b1);
    checkState("verdict");
  endtask

  task automatic lockWindow(input bit tryEnter);
    int hi;
    int guard;
    int shiftsBefore;
    hi = (lockout === 1'b1) ? 1 : 0;
    guard = 0;
    shiftsBefore = shiftSeen;
    fork
      begin
        while (lockout === 1'b1 && guard < 40) begin
          @(negedge clk);
          if (lockout === 1'b1) hi++;
          guard++;
        end
      end
      begin
        if (tryEnter) pressRaw(1'b0, 1'b0, 1'b1, 1'b0);
      end
    join
    chk("lockout_length", hi, LOCKOUT_CYCLES);
    chk("lockout_enter_dropped", shiftSeen, shiftsBefore);
    mFails = 0; mBusy = 1'b0; mLock = 1'b0;
    checkState("after_lockout");
  endtask

  initial begin
    int k;
    int guard;

    // Reset values
    repeat (3) @(negedge clk);
    chk("reset.shift_en", shift_en, 1'b0);
    chk("reset.pin_clr", pin_clr, 1'b0);
    chk("reset.check", check, 1'b0);
    checkState("reset");
    rst = 1'b1;

    // Three-edge latency from button to digit
    @(negedge clk); btn_up = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("latency.edge2", digit, 4'h0);
    @(posedge clk); #1;
    chk("latency.edge3", digit, 4'h1);
    btn_up = 1'b0;
    mDigit = 1;
    repeat (4) @(negedge clk);

    // 3, F, 0, 0 then check one cycle after the last shift
    doPress(1'b1, 1'b0, 1'b0, 1'b0);
    doPress(1'b1, 1'b0, 1'b0, 1'b0);
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    doPress(1'b0, 1'b1, 1'b0, 1'b0);
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    chk("pin1.count", shiftLog.size(), 4);
    if (shiftLog.size() >= 4) begin
      chk("pin1.d0", shiftLog[0], 4'h3);
      chk("pin1.d1", shiftLog[1], 4'hF);
      chk("pin1.d2", shiftLog[2], 4'h0);
      chk("pin1.d3", shiftLog[3], 4'h0);
    end
    chk("pin1.check_gap", lastCheckCyc - lastShiftCyc, 1);
    verdict(1'b1);

    // Three mismatches into lockout, enter pressed during lockout
    for (int i = 0; i < MAX_FAILS; i++) begin
      enterPin();
      verdict(1'b0);
    end
    lockWindow(1'b1);

    // Clear beats enter; up and down cancel
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    doPress(1'b0, 1'b0, 1'b1, 1'b1);
    doPress(1'b1, 1'b0, 1'b0, 1'b0);
    doPress(1'b1, 1'b1, 1'b0, 1'b0);
    doPress(1'b1, 1'b0, 1'b1, 1'b0);
    doPress(1'b0, 1'b0, 1'b0, 1'b1);

    // Randomized PIN rounds
    for (int r = 0; r < 8; r++) begin
      guard = 0;
      while (!mBusy && guard < 200) begin
        k = $urandom_range(0, 15);
        case (k)
          0, 1, 2, 3: doPress(1'b1, 1'b0, 1'b0, 1'b0);
          4, 5, 6:    doPress(1'b0, 1'b1, 1'b0, 1'b0);
          7:          doPress(1'b1, 1'b1, 1'b0, 1'b0);
          8:          doPress(1'b0, 1'b0, 1'b0, 1'b1);
          9:          doPress(1'b1, 1'b0, 1'b1, 1'b0);
          10:         doPress(1'b0, 1'b1, 1'b1, 1'b0);
          default:    doPress(1'b0, 1'b0, 1'b1, 1'b0);
        endcase
        guard++;
      end
      chk("random.pin_complete", mBusy, 1'b1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      verdict(1'($urandom_range(0, 1)));
      if (mLock) lockWindow(1'b0);
    end

    // Idle partial entry
    doPress(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (TIMEOUT_CYCLES + 4) @(negedge clk);
`ifdef ENTRY_TIMEOUT_EN
    mCount = 0; mDigit = 0; expClr++;
`endif
    checkState("idle");
    doPress(1'b0, 1'b0, 1'b0, 1'b1);

    // Reset while waiting for a verdict
    enterPin();
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("midreset.shift_en", shift_en, 1'b0);
    chk("midreset.pin_clr", pin_clr, 1'b0);
    chk("midreset.check", check, 1'b0);
    mDigit = 0; mCount = 0; mFails = 0; mBusy = 1'b0; mLock = 1'b0;
    checkState("midreset");
    rst = 1'b1;
    @(negedge clk); result_valid = 1'b1; result_match = 1'b0;
    @(negedge clk); result_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkState("ignored_verdict");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
